// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: loadable multi-digit BCD down-counter with a start/stop
// FSM and a one-cycle terminal pulse on z.
// Optional feature: define RELOAD_EN for auto-reload from the preset register
// at terminal count (otherwise one-shot).
module bcd_countdown_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  start,
  input  logic                  x,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  z,
  output logic                  busy
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   q_r, q_n;
  logic [W-1:0]   preset_r, preset_n;
  logic           z_r, z_n;
  logic [W-1:0]   din_sat;
  logic           at_one;

  // Clamp every nibble to 9 so the stored value is always valid BCD.
  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  // BCD subtract-one: a digit at 0 wraps to 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Sanitized preset and terminal-count decode.
  always_comb begin
    din_sat = bcd_sat(din);
    at_one  = (q_r == W'(1));
  end

  // Next-state logic: load beats everything, then start/decrement/terminal.
  always_comb begin
    state_n  = state;
    q_n      = q_r;
    preset_n = preset_r;
    z_n      = 1'b0;
    if (load) begin
      q_n      = din_sat;
      preset_n = din_sat;
      state_n  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && (q_r != '0)) begin
            state_n = RUN;
          end
        end
        RUN: begin
          if (x) begin
            if (at_one) begin
              z_n = 1'b1;
`ifdef RELOAD_EN
              if (preset_r != '0) begin
                q_n = preset_r;
              end else begin
                q_n     = '0;
                state_n = IDLE;
              end
`else
              q_n     = '0;
              state_n = IDLE;
`endif
            end else if (q_r == '0) begin
              // Unreachable in normal use; never wrap below zero.
              state_n = IDLE;
            end else begin
              q_n = bcd_dec(q_r);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, count, preset and pulse registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      q_r      <= '0;
      preset_r <= '0;
      z_r      <= 1'b0;
    end else begin
      state    <= state_n;
      q_r      <= q_n;
      preset_r <= preset_n;
      z_r      <= z_n;
    end
  end

  assign Q    = q_r;
  assign z    = z_r;
  assign busy = (state == RUN);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (DIGITS=2): directed scenarios
// plus randomized traffic against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;

  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic         start;
  logic         x;
  logic [W-1:0] din;
  logic [W-1:0] Q;
  logic         z;
  logic         busy;

  int checks = 0;
  int passes = 0;

  // Reference model state: count as a plain decimal integer.
  int m_val = 0;
  int m_pre = 0;
  bit m_run = 1'b0;
  bit m_z   = 1'b0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .start (start),
    .x     (x),
    .din   (din),
    .Q     (Q),
    .z     (z),
    .busy  (busy)
  );

  // Decimal value of a packed word with each nibble clamped to 9.
  function automatic int san_val(input logic [W-1:0] d);
    int r;
    int p;
    int n;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(d[4*i +: 4]);
      if (n > 9) n = 9;
      r = r + n * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Advance the model with the current inputs, then let the DUT take one edge.
  task automatic cycle();
    if (load) begin
      m_val = san_val(din);
      m_pre = m_val;
      m_run = 1'b0;
      m_z   = 1'b0;
    end else if (!m_run) begin
      m_z = 1'b0;
      if (start && m_val != 0) m_run = 1'b1;
    end else if (x) begin
      if (m_val == 1) begin
        m_z = 1'b1;
`ifdef RELOAD_EN
        if (m_pre != 0) m_val = m_pre;
        else begin m_val = 0; m_run = 1'b0; end
`else
        m_val = 0;
        m_run = 1'b0;
`endif
      end else begin
        m_val = m_val - 1;
        m_z   = 1'b0;
      end
    end else begin
      m_z = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; x = 1'b0; din = '0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; din = v; cycle(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    checks++; if (Q !== 8'h00) $display("FAIL reset_q got %h want 00", Q); else passes++;
    checks++; if (z !== 1'b0) $display("FAIL reset_z got %b want 0", z); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_sanitize();
    do_load(8'hA5);
    checks++; if (Q !== 8'h95) $display("FAIL load_A5 got %h want 95", Q); else passes++;
    do_load(8'h3F);
    checks++; if (Q !== 8'h39) $display("FAIL load_3F got %h want 39", Q); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL load_busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_countdown();
    logic [W-1:0] exp;
    do_load(8'h12);
    do_start();
    checks++; if (busy !== 1'b1) $display("FAIL cd_busy_start got %b want 1", busy); else passes++;
    checks++; if (Q !== 8'h12) $display("FAIL cd_first_run got %h want 12", Q); else passes++;
    x = 1'b1;
    for (int k = 11; k >= 0; k--) begin
      cycle();
      exp = to_bcd(k);
      checks++; if (Q !== exp) $display("FAIL cd_q step %0d got %h want %h", k, Q, exp); else passes++;
      if (k == 0) begin
        checks++; if (z !== 1'b1) $display("FAIL cd_z_terminal got %b want 1", z); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL cd_busy_terminal got %b want 0", busy); else passes++;
      end else begin
        checks++; if (z !== 1'b0) $display("FAIL cd_z_early step %0d got %b want 0", k, z); else passes++;
      end
    end
    cycle();
    checks++; if (z !== 1'b0) $display("FAIL cd_z_after got %b want 0", z); else passes++;
    checks++; if (Q !== 8'h00) $display("FAIL cd_no_underflow got %h want 00", Q); else passes++;
    x = 1'b0;
  endtask

  task automatic test_borrow();
    do_load(8'h20);
    do_start();
    x = 1'b1; cycle();
    checks++; if (Q !== 8'h19) $display("FAIL borrow_1 got %h want 19", Q); else passes++;
    x = 1'b0; cycle();
    checks++; if (Q !== 8'h19) $display("FAIL borrow_hold got %h want 19", Q); else passes++;
    x = 1'b1; cycle();
    checks++; if (Q !== 8'h18) $display("FAIL borrow_2 got %h want 18", Q); else passes++;
    x = 1'b0;
  endtask

  task automatic test_load_vs_terminal();
    do_load(8'h01);
    do_start();
    x = 1'b1; load = 1'b1; din = 8'h50;
    cycle();
    load = 1'b0; x = 1'b0;
    checks++; if (Q !== 8'h50) $display("FAIL lt_q got %h want 50", Q); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL lt_busy got %b want 0", busy); else passes++;
    checks++; if (z !== 1'b0) $display("FAIL lt_z got %b want 0", z); else passes++;
    // load together with start in IDLE: load wins, stays IDLE
    load = 1'b1; start = 1'b1; din = 8'h07;
    cycle();
    load = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL ls_busy got %b want 0", busy); else passes++;
    checks++; if (Q !== 8'h07) $display("FAIL ls_q got %h want 07", Q); else passes++;
  endtask

  task automatic test_start_zero();
    do_load(8'h00);
    do_start();
    checks++; if (busy !== 1'b0) $display("FAIL start_zero_busy got %b want 0", busy); else passes++;
    x = 1'b1; cycle(); x = 1'b0;
    checks++; if (Q !== 8'h00) $display("FAIL start_zero_q got %h want 00", Q); else passes++;
    checks++; if (z !== 1'b0) $display("FAIL start_zero_z got %b want 0", z); else passes++;
  endtask

  task automatic test_reset_mid_run();
    do_load(8'h37);
    do_start();
    cycle();
    #3;
    reset = 1'b0;
    #1;
    checks++; if (Q !== 8'h00) $display("FAIL async_q got %h want 00", Q); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL async_busy got %b want 0", busy); else passes++;
    checks++; if (z !== 1'b0) $display("FAIL async_z got %b want 0", z); else passes++;
    #2;
    reset = 1'b1;
    m_val = 0; m_pre = 0; m_run = 1'b0; m_z = 1'b0;
    x = 1'b1; cycle(); x = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy); else passes++;
  endtask

`ifdef RELOAD_EN
  task automatic test_reload();
    logic [W-1:0] seq [6] = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
    do_load(8'h03);
    do_start();
    x = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (Q !== seq[i]) $display("FAIL reload_q %0d got %h want %h", i, Q, seq[i]); else passes++;
      checks++; if (z !== (seq[i] == 8'h03)) $display("FAIL reload_z %0d got %b", i, z); else passes++;
      checks++; if (busy !== 1'b1) $display("FAIL reload_busy %0d got %b want 1", i, busy); else passes++;
    end
    x = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] exp;
    for (int n = 0; n < 400; n++) begin
      load  = ($urandom_range(0, 15) == 0);
      din   = ($urandom_range(0, 1) == 1) ? W'($urandom) : to_bcd(int'($urandom_range(0, 6)));
      start = ($urandom_range(0, 3) == 0);
      x     = ($urandom_range(0, 3) != 0);
      cycle();
      exp = to_bcd(m_val);
      checks++; if (Q !== exp) $display("FAIL rand_q cyc %0d got %h want %h", n, Q, exp); else passes++;
      checks++; if (z !== m_z) $display("FAIL rand_z cyc %0d got %b want %b", n, z, m_z); else passes++;
      checks++; if (busy !== m_run) $display("FAIL rand_busy cyc %0d got %b want %b", n, busy, m_run); else passes++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_sanitize();
    test_countdown();
    test_borrow();
    test_load_vs_terminal();
    test_start_zero();
    test_reset_mid_run();
`ifdef RELOAD_EN
    test_reload();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
